// File: rtl/pattern_detector.sv
// ---------------------------------------------------------------------------
// pattern_detector
// Serial pattern detector. Compares a qualified serial bit stream against a
// run-time loadable LEN-bit pattern using a full LEN-bit history window.
// Supports overlapping and non-overlapping matches and produces a registered
// one-cycle match pulse plus an optional saturating match counter.
//
// Optional feature macro: PATTERN_DETECTOR_COUNT_EN
//   defined   -> match_count is a saturating CNT_W-bit counter of matches
//   undefined -> no counter logic, match_count tied to 0
//
// Parameters:
//   LEN      pattern length in bits (2..32)
//   PATTERN  pattern loaded at reset, PATTERN[LEN-1] is the first bit on wire
//   CNT_W    match counter width
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   x            serial data bit
//   x_valid      x is sampled when high
//   overlap      1 = overlapping matches, 0 = non-overlapping
//   pat_in       new pattern value
//   pat_load     load pat_in, clear fill, drop the bit of this cycle
//   z            registered one-cycle match pulse
//   match_count  saturating match count
// ---------------------------------------------------------------------------
module pattern_detector #(
  parameter int unsigned       LEN     = 4,
  parameter logic [LEN-1:0]    PATTERN = LEN'(4'b0110),
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic [LEN-1:0]   pat_in,
  input  logic             pat_load,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned FILL_W = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

  logic [LEN-1:0]    pat_q,  pat_d;
  logic [LEN-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] fill_inc_c;
  logic              z_q,    z_d;
  logic              match_c;

  // Next-state: pattern load wins over data, data only on x_valid.
  always_comb begin
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    z_d        = 1'b0;
    match_c    = 1'b0;
    fill_inc_c = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (x_valid) begin
      hist_d  = {hist_q[LEN-2:0], x};
      match_c = (fill_inc_c == FILL_FULL) && (hist_d == pat_q);
      // Non-overlapping mode needs LEN fresh bits after a match.
      fill_d  = (match_c && !overlap) ? '0 : fill_inc_c;
      z_d     = match_c;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  assign z = z_q;

`ifdef PATTERN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter; holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (match_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised serial pattern detector: the next generation of the team's fixed 4-state "0110" Mealy detector. It compares a qualified serial bit stream against a run-time-loadable LEN-bit pattern, supports overlapping and non-overlapping match modes, and emits a registered one-cycle match pulse. It sits behind a serial receiver or bit slicer and feeds status/interrupt logic.

## Interface
- `LEN`, default 4: pattern length in bits; legal range 2..32.
- `PATTERN`, default 4'b0110: pattern loaded at reset. `PATTERN[LEN-1]` is the first bit expected on the wire.
- `CNT_W`, default 8: width of the match counter.
- `clk`, input, 1: single clock; all state changes on rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `x`, input, 1: serial data bit.
- `x_valid`, input, 1: `x` is sampled only when this is high at a rising edge.
- `overlap`, input, 1: 1 selects overlapping matches, 0 selects non-overlapping. Sampled each cycle.
- `pat_in`, input, LEN: new pattern value.
- `pat_load`, input, 1: loads `pat_in` into the pattern register.
- `z`, output, 1: registered match pulse.
- `match_count`, output, CNT_W: saturating count of matches.

## Operation
- State:
  - pattern register `pat` (LEN bits);
  - history shift register `hist` (LEN bits, newest bit at bit 0);
  - fill counter `fill` (0..LEN, $clog2(LEN+1) bits): number of valid history bits since the last clear.
- Reset values: `pat`=PATTERN, `hist`=0, `fill`=0, `z`=0, `match_count`=0.
- Accepted bit, i.e. `x_valid`=1 and `pat_load`=0:
  - `hist_next` = {hist[LEN-2:0], x};
  - `fill_next` = min(fill+1, LEN);
  - match when `fill_next`==LEN and `hist_next`==`pat`.
- On match:
  - `z` goes to 1 in the next cycle.
  - `match_count` increments, holding at 2^CNT_W−1 once it gets there (saturating, no wrap).
  - `overlap`=1: `hist` and `fill` update normally, so the bits just matched are reused.
  - `overlap`=0: `fill` is cleared to 0 (`hist` still shifts), so the next match needs LEN fresh accepted bits.
- No match: `z` goes to 0.
- `x_valid`=0: `hist` and `fill` hold; `z` goes to 0. Idle gaps do not break a partial match.
- `pat_load`=1:
  - `pat` is set to `pat_in`, `fill` to 0 and `z` to 0; `match_count` is kept.
  - Any bit presented in the same cycle is discarded, regardless of `x_valid`.
- Partial matches are never checked with a shorter prefix. Detection relies only on the full LEN-bit window, so no failure-function logic is needed.

## Timing
- Latency: `z` is high in the cycle right after the rising edge that accepted the last bit of the pattern, and stays high for exactly one cycle per match.
- `match_count` updates on the same edge that sets `z`.
- Back-to-back matches in overlap mode give consecutive `z` pulses. An all-ones pattern with continuous ones gives a match on every accepted bit from the LEN-th bit onward.
- Reset during a stream clears a partial match at once. The first possible match after reset is on the LEN-th accepted bit.
- `overlap` is applied using its value at the matching edge. Changing it between matches has no other effect.

## Configuration
- Macro: `PATTERN_DETECTOR_COUNT_EN`.
- Defined: the `match_count` register and its saturating increment are built as described above.
- Undefined: no counter logic is built, and `match_count` is tied to 0. `z` behaviour does not change.

## Test plan
- LEN=4, `pat`=0110, `overlap`=1, stream 0,1,1,0,1,1,0 (`x_valid`=1 continuously) -> `z` pulses after bits 4 and 7; `match_count`=2.
- Same stream with `overlap`=0 -> `z` pulses only after bit 4; `match_count`=1. Stream 0110 0110 -> two pulses in both modes.
- Stream 0,1,gap(3 cycles x_valid=0),1,0 -> one `z` pulse, in the cycle after the final 0 is accepted.
- CNT_W=2, `pat`=1111, `overlap`=1, eight consecutive ones -> five `z` pulses; `match_count` stops at 3. With the macro undefined, `match_count` stays 0.
- Load `pat_in`=1001 after bits 0,1,1 with `x_valid`=1 in the same cycle -> that cycle's bit is dropped. Then 1,0,0,1 -> one pulse; the earlier 0110 tail does not match.
- Assert `reset` asynchronously after 0,1,1 -> `z`=0 and `match_count`=0 immediately, `pat` back to PATTERN. A following lone 0 gives no pulse; a full 0110 gives one pulse.
